// File: rtl/cic_up_s3.sv
// 3-stage CIC interpolator: low-rate comb chain, zero-stuffing upsampler,
// high-rate integrator chain and output register, all modulo 2^OUTPUT_WIDTH.
module cic_up_s3 #(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_enable,
  input  logic [15:0]                    FACTOR,
  input  logic signed [INPUT_WIDTH-1:0]  filter_in,
  output logic                           ce_in,
  output logic signed [OUTPUT_WIDTH-1:0] filter_out,
  output logic                           ce_out
);

  localparam int W = OUTPUT_WIDTH;
  typedef logic signed [W-1:0] acc_t;

  logic [15:0] r_minus1;
  logic [15:0] cur_count_q, cur_count_d;

  acc_t x, c1, c2, c3, u;
  acc_t d1_q, d2_q, d3_q, comb_out_q;
  acc_t a1_q, a2_q, a3_q, out_q;
  logic fresh_q;
  logic ce_out_q;

  // FACTOR of 0 and 1 both give a ratio of one, so the counter never leaves 0.
  assign r_minus1 = (FACTOR == 16'd0) ? 16'd0 : FACTOR - 16'd1;

  // A comparison rather than equality lets a shrinking FACTOR wrap immediately.
  assign cur_count_d = (cur_count_q >= r_minus1) ? 16'd0 : cur_count_q + 16'd1;

  assign ce_in = clk_enable && (cur_count_q == 16'd0);

  assign x  = acc_t'(filter_in);
  assign c1 = x  - d1_q;
  assign c2 = c1 - d2_q;
  assign c3 = c2 - d3_q;

  // Zero-stuff: the comb result enters the integrators for exactly one clock.
  assign u = fresh_q ? comb_out_q : '0;

  // NOTE: non-blocking assignments make every integrator read the previous
  // value of its predecessor, which is what gives the pipeline its latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_count_q <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      comb_out_q  <= '0;
      fresh_q     <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      a3_q        <= '0;
      out_q       <= '0;
      ce_out_q    <= 1'b0;
    end else begin
      ce_out_q <= clk_enable;
      if (clk_enable) begin
        cur_count_q <= cur_count_d;
        fresh_q     <= ce_in;
        a1_q        <= a1_q + u;
        a2_q        <= a2_q + a1_q;
        a3_q        <= a3_q + a2_q;
        out_q       <= a3_q;
        if (ce_in) begin
          d1_q       <= x;
          d2_q       <= c1;
          d3_q       <= c2;
          comb_out_q <= c3;
        end
      end
    end
  end

  assign filter_out = out_q;
  assign ce_out     = ce_out_q;

endmodule

// File: tb/tb_cic_up_s3.sv
// Directed bench for cic_up_s3: impulse/step responses, R=1 pass-through,
// wrap at full scale, enable gating, FACTOR change and mid-stream reset.
module tb_cic_up_s3;

  logic               clk;
  logic               reset;
  logic               clk_enable;
  logic [15:0]        FACTOR;
  logic signed [11:0] filter_in;
  logic               ce_in;
  logic signed [14:0] filter_out;
  logic               ce_out;

  cic_up_s3 #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .FACTOR     (FACTOR),
    .filter_in  (filter_in),
    .ce_in      (ce_in),
    .filter_out (filter_out),
    .ce_out     (ce_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived responses: R=2 impulse, R=4 impulse, R=4 step of height 5.
  localparam int H2 [4]  = '{1, 3, 3, 1};
  localparam int H4 [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
  localparam int S5 [6]  = '{5, 15, 30, 50, 65, 75};

  int n_total;
  int n_pass;
  int exp_v;
  int last_exp;
  int n_en;
  logic en;
  logic signed [11:0] xs [40];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_total    = 0;
    n_pass     = 0;
    reset      = 1'b1;
    clk_enable = 1'b1;
    FACTOR     = 16'd2;
    filter_in  = '0;
    tick();
    tick();
    check("rst_filter_out", filter_out, 0);
    check("rst_ce_out", ce_out, 0);
    check("rst_ce_in", ce_in, 1);

    // T1: R=2 impulse
    reset     = 1'b0;
    filter_in = 12'sd1;
    #1;
    check("t1_ce_in_first", ce_in, 1);
    for (int k = 0; k < 14; k++) begin
      tick();
      filter_in = '0;
      exp_v = (k >= 4 && k <= 7) ? H2[k-4] : 0;
      check("t1_filter_out", filter_out, exp_v);
      check("t1_ce_in", ce_in, ((k + 1) % 2) == 0);
    end
    check("t1_ce_out", ce_out, 1);

    // T2: R=4 impulse
    FACTOR = 16'd4;
    do_reset();
    filter_in = 12'sd1;
    #1;
    check("t2_ce_in_first", ce_in, 1);
    for (int k = 0; k < 18; k++) begin
      tick();
      filter_in = '0;
      exp_v = (k >= 4 && k <= 13) ? H4[k-4] : 0;
      check("t2_filter_out", filter_out, exp_v);
      check("t2_ce_in", ce_in, ((k + 1) % 4) == 0);
    end

    // T3: R=4 constant 5 settles at 5*16
    do_reset();
    filter_in = 12'sd5;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_v = (k < 4) ? 0 : ((k - 4 < 6) ? S5[k-4] : 80);
      check("t3_filter_out", filter_out, exp_v);
    end

    // T5: R=4 full-scale constant wraps to -16
    do_reset();
    filter_in = 12'sd2047;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (k >= 12) check("t5_filter_out", filter_out, -16);
    end

    // T4: R=1 (FACTOR 1 then 0) is a 4-clock delay
    FACTOR = 16'd1;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      xs[k]     = 12'($urandom);
      filter_in = xs[k];
      FACTOR    = (k < 20) ? 16'd1 : 16'd0;
      #1;
      check("t4_ce_in", ce_in, 1);
      tick();
      if (k >= 4) check("t4_filter_out", filter_out, 32'(xs[k-4]));
    end

    // T6a: R=4 impulse with random clk_enable gaps
    FACTOR = 16'd4;
    do_reset();
    n_en     = 0;
    last_exp = 0;
    for (int i = 0; i < 60; i++) begin
      en         = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      clk_enable = en;
      filter_in  = (n_en == 0) ? 12'sd1 : 12'sd0;
      #1;
      check("t6_ce_in", ce_in, en && ((n_en % 4) == 0));
      tick();
      if (en) begin
        last_exp = (n_en >= 4 && n_en <= 13) ? H4[n_en-4] : 0;
        n_en++;
        check("t6_ce_out_on", ce_out, 1);
      end else begin
        check("t6_ce_out_off", ce_out, 0);
      end
      check("t6_filter_out", filter_out, last_exp);
    end
    clk_enable = 1'b1;

    // T6b: FACTOR 4->2 while cur_count=3 wraps on the next enabled edge
    filter_in = '0;
    do_reset();
    tick();
    tick();
    tick();
    FACTOR = 16'd2;
    #1;
    check("t6_count3_ce_in", ce_in, 0);
    tick();
    check("t6_wrap_ce_in", ce_in, 1);
    tick();
    check("t6_r2_ce_in_lo", ce_in, 0);
    tick();
    check("t6_r2_ce_in_hi", ce_in, 1);

    // T6c: reset mid-impulse, with clk_enable low, discards history
    FACTOR = 16'd4;
    do_reset();
    filter_in = 12'sd1;
    tick();
    filter_in = '0;
    for (int k = 1; k <= 6; k++) tick();
    check("t6_pre_reset", filter_out, 6);
    reset      = 1'b1;
    clk_enable = 1'b0;
    tick();
    check("t6_rst_filter_out", filter_out, 0);
    check("t6_rst_ce_out", ce_out, 0);
    reset      = 1'b0;
    clk_enable = 1'b1;
    #1;
    check("t6_rst_ce_in", ce_in, 1);
    tick();
    check("t6_post_rst_ce_in", ce_in, 0);
    for (int k = 1; k < 14; k++) begin
      tick();
      check("t6_post_rst_out", filter_out, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
